// File: rtl/cycles_period_meter_pkg.sv
// Shared types and constants for the cycles period meter.
// The top level derives its own all-ones limit from its WIDTH parameter.
package cycles_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } meter_state_t;

  localparam int DEFAULT_WIDTH = 28;
  localparam logic [DEFAULT_WIDTH-1:0] CNT_MAX = {DEFAULT_WIDTH{1'b1}};

endpackage

// File: rtl/cycles_period_meter_event_edge_sync.sv
// Optional input synchroniser followed by a registered rising-edge detector.
// The rise output is one cycle behind the synchronised level.
module event_edge_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic event_in,
  output logic rise
);

  logic ev_s;
  logic ev_d_reg;
  logic rise_reg;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign ev_s = event_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg[0] <= event_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
          end
        end
      end

      assign ev_s = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  // ev_d clears on reset, so a level already high when reset lifts yields one rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      ev_d_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      ev_d_reg <= ev_s;
      rise_reg <= ev_s & ~ev_d_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/cycles_period_meter.sv
// Counts clock cycles between consecutive rising edges of event_in and hands each
// period to the consumer through a single valid/ready output register.
module cycles_period_meter
  import cycles_meter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             event_in,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overflow,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] CNT_MAX_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

  meter_state_t     state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             sat_reg, sat_next;
  logic [WIDTH-1:0] period_reg;
  logic             valid_reg;
  logic             overflow_reg;
  logic             overrun_reg;
  logic             rise;
  logic             result_event;
  logic             load;
  logic             drop;

  event_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clock   (clock),
    .reset   (reset),
    .event_in(event_in),
    .rise    (rise)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      sat_reg   <= sat_next;
    end
  end

  // sat_reg marks a count that tried to pass CNT_MAX, so an exact CNT_MAX period is not flagged.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    sat_next     = sat_reg;
    result_event = 1'b0;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        sat_next   = 1'b0;
        if (enable) state_next = ARM;
      end
      ARM: begin
        if (rise) begin
          state_next = MEASURE;
          count_next = CNT_ONE;
          sat_next   = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          result_event = 1'b1;
          count_next   = CNT_ONE;
          sat_next     = 1'b0;
        end else if (count_reg == CNT_MAX_W) begin
          sat_next = 1'b1;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!enable) begin
      state_next   = IDLE;
      count_next   = '0;
      sat_next     = 1'b0;
      result_event = 1'b0;
    end
  end

  assign load = result_event && (!valid_reg || period_ready);
  assign drop = result_event && valid_reg && !period_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      period_reg   <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (load) begin
        period_reg   <= count_reg;
        overflow_reg <= sat_reg;
        valid_reg    <= 1'b1;
      end else if (valid_reg && period_ready) begin
        valid_reg <= 1'b0;
      end
      if (drop) overrun_reg <= 1'b1;
    end
  end

  assign period_out   = period_reg;
  assign period_valid = valid_reg;
  assign overflow     = overflow_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_cycles_period_meter.sv
// Directed bench for cycles_period_meter: a default-width instance and a 4-bit
// instance share stimulus; accepted results are captured on each handshake.
module tb_cycles_period_meter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        event_in = 1'b0;
  logic        ready = 1'b0;
  logic [27:0] p28;
  logic        v28, o28, or28;
  logic [3:0]  p4;
  logic        v4, o4, or4;

  int tests_run = 0;
  int tests_failed = 0;

  int unsigned q28[$];
  bit          qo28[$];
  int unsigned q4[$];
  bit          qo4[$];

  always #5 clock = ~clock;

  cycles_period_meter dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .event_in    (event_in),
    .period_out  (p28),
    .period_valid(v28),
    .period_ready(ready),
    .overflow    (o28),
    .overrun     (or28)
  );

  cycles_period_meter #(.WIDTH(4)) dut_w4 (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .event_in    (event_in),
    .period_out  (p4),
    .period_valid(v4),
    .period_ready(ready),
    .overflow    (o4),
    .overrun     (or4)
  );

  // A result is consumed at the next rising edge when valid and ready are both high.
  always @(negedge clock) begin
    if (!reset) begin
      if (v28 && ready) begin
        q28.push_back(int'(p28));
        qo28.push_back(o28);
      end
      if (v4 && ready) begin
        q4.push_back(int'(p4));
        qo4.push_back(o4);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_gap(input int n);
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    repeat (n - 1) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    ready = 1'b0;
    event_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    q28.delete();
    qo28.delete();
    q4.delete();
    qo4.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (p28 !== 28'd0) begin tests_failed++; $display("FAIL reset_period_out: got %0d expected 0", p28); end
    tests_run++;
    if (v28 !== 1'b0) begin tests_failed++; $display("FAIL reset_period_valid: got %b expected 0", v28); end
    tests_run++;
    if (o28 !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", o28); end
    tests_run++;
    if (or28 !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", or28); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_loopback();
    do_reset();
    enable = 1'b1;
    ready = 1'b1;
    tick();
    tick();
    repeat (4) pulse_gap(10);
    tick();
    tests_run++;
    if (q28.size() != 3) begin
      tests_failed++;
      $display("FAIL loopback_count: got %0d results expected 3", q28.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (q28[i] != 10 || qo28[i] != 1'b0) begin
          tests_failed++;
          $display("FAIL loopback_result%0d: got %0d ovf %0d expected 10 ovf 0", i, q28[i], qo28[i]);
        end
      end
    end
    tests_run++;
    if (or28 !== 1'b0) begin tests_failed++; $display("FAIL loopback_overrun: got %b expected 0", or28); end
    $display("[TB] test_loopback: %0d results", q28.size());
  endtask

  task automatic test_saturation();
    int unsigned exp4[4];
    bit          expo4[4];
    int unsigned exp28[4];
    exp4  = '{15, 5, 15, 2};
    expo4 = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp28 = '{20, 5, 15, 2};
    do_reset();
    enable = 1'b1;
    ready = 1'b1;
    tick();
    tick();
    pulse_gap(20);
    pulse_gap(5);
    pulse_gap(15);
    pulse_gap(2);
    pulse_gap(3);
    tests_run++;
    if (q4.size() != 4 || q28.size() != 4) begin
      tests_failed++;
      $display("FAIL sat_count: got %0d/%0d results expected 4/4", q4.size(), q28.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (q4[i] != exp4[i] || qo4[i] != expo4[i]) begin
          tests_failed++;
          $display("FAIL sat_w4_result%0d: got %0d ovf %0d expected %0d ovf %0d", i, q4[i], qo4[i], exp4[i], expo4[i]);
        end
        tests_run++;
        if (q28[i] != exp28[i] || qo28[i] != 1'b0) begin
          tests_failed++;
          $display("FAIL sat_w28_result%0d: got %0d ovf %0d expected %0d ovf 0", i, q28[i], qo28[i], exp28[i]);
        end
      end
    end
    $display("[TB] test_saturation: %0d results", q4.size());
  endtask

  task automatic test_overrun();
    do_reset();
    enable = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    pulse_gap(8);
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tests_run++;
    if (v28 !== 1'b0) begin tests_failed++; $display("FAIL overrun_latency_early: got valid %b expected 0", v28); end
    tick();
    tests_run++;
    if (v28 !== 1'b1 || p28 !== 28'd8 || or28 !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_first: got valid %b period %0d overrun %b expected 1 8 0", v28, p28, or28);
    end
    repeat (6) tick();
    pulse_gap(8);
    tests_run++;
    if (v28 !== 1'b1 || p28 !== 28'd8 || or28 !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_held: got valid %b period %0d overrun %b expected 1 8 1", v28, p28, or28);
    end
    ready = 1'b1;
    tick();
    tests_run++;
    if (v28 !== 1'b0 || or28 !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_consume: got valid %b overrun %b expected 0 1", v28, or28);
    end
    tests_run++;
    if (q28.size() != 1 || q28[0] != 8) begin
      tests_failed++;
      $display("FAIL overrun_accepted: got %0d results first %0d expected 1 result 8", q28.size(), (q28.size() > 0) ? q28[0] : 0);
    end
    $display("[TB] test_overrun: overrun=%b", or28);
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    pulse_gap(4);
    pulse_gap(3);
    tests_run++;
    if (v28 !== 1'b1 || p28 !== 28'd4) begin
      tests_failed++;
      $display("FAIL b2b_first: got valid %b period %0d expected 1 4", v28, p28);
    end
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    ready = 1'b1;
    tests_run++;
    if (v28 !== 1'b1 || p28 !== 28'd4) begin
      tests_failed++;
      $display("FAIL b2b_before_load: got valid %b period %0d expected 1 4", v28, p28);
    end
    tick();
    tests_run++;
    if (v28 !== 1'b1 || p28 !== 28'd3 || or28 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_load: got valid %b period %0d overrun %b expected 1 3 0", v28, p28, or28);
    end
    tick();
    tests_run++;
    if (v28 !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got valid %b expected 0", v28); end
    tests_run++;
    if (q28.size() != 2 || q28[0] != 4 || q28[1] != 3) begin
      tests_failed++;
      $display("FAIL b2b_sequence: got %0d results expected 4 then 3", q28.size());
    end
    $display("[TB] test_back_to_back: %0d results", q28.size());
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1;
    ready = 1'b1;
    tick();
    tick();
    pulse_gap(3);
    enable = 1'b0;
    tick();
    pulse_gap(4);
    tests_run++;
    if (v28 !== 1'b0 || q28.size() != 0) begin
      tests_failed++;
      $display("FAIL enable_partial: got valid %b results %0d expected 0 0", v28, q28.size());
    end
    enable = 1'b1;
    tick();
    tick();
    pulse_gap(6);
    pulse_gap(6);
    tests_run++;
    if (q28.size() != 1 || q28[0] != 6) begin
      tests_failed++;
      $display("FAIL enable_rearm: got %0d results first %0d expected 1 result 6", q28.size(), (q28.size() > 0) ? q28[0] : 0);
    end
    $display("[TB] test_enable_drop: %0d results", q28.size());
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    pulse_gap(8);
    pulse_gap(8);
    pulse_gap(3);
    tests_run++;
    if (v28 !== 1'b1 || p28 !== 28'd8 || or28 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pending: got valid %b period %0d overrun %b expected 1 8 1", v28, p28, or28);
    end
    event_in = 1'b1;
    reset = 1'b1;
    tick();
    tests_run++;
    if (v28 !== 1'b0 || p28 !== 28'd0 || o28 !== 1'b0 || or28 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_cleared: got valid %b period %0d ovf %b overrun %b expected all 0", v28, p28, o28, or28);
    end
    reset = 1'b0;
    ready = 1'b1;
    repeat (20) tick();
    tests_run++;
    if (v28 !== 1'b0 || q28.size() != 0) begin
      tests_failed++;
      $display("FAIL rstmid_held_high: got valid %b results %0d expected 0 0", v28, q28.size());
    end
    event_in = 1'b0;
    tick();
    pulse_gap(7);
    pulse_gap(7);
    pulse_gap(7);
    tests_run++;
    if (q28.size() == 0 || q28[q28.size()-1] != 7) begin
      tests_failed++;
      $display("FAIL rstmid_recover: got %0d results last %0d expected last 7", q28.size(), (q28.size() > 0) ? q28[q28.size()-1] : 0);
    end
    $display("[TB] test_reset_mid: %0d results", q28.size());
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
